mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
Memory-side responder for the 16-bit multicycle core. It serves the fetch stage's instruction read in phase 1 and the load/store access in phase 4 against a synchronous single-port RAM. It drives data_bus, which the fetch stage latches in phase 1, and load_data for the writeback path. It holds the phase sequencer with phase_stall while a read is outstanding.

Parameters:
ADDR_WIDTH, 12, implemented RAM word-address width; RAM depth is 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from ram_addr valid to ram_rdata valid; legal range 1..4.

Ports:
clock  input  1  system clock, all state updates on the rising edge
reset  input  1  synchronous, active-low
phase_counter  input  3  current phase from the sequencer; 3'b001 = fetch, 3'b100 = memory
program_counter  input  16  instruction word address
op_load  input  1  current instruction is a load (sampled in phase 4)
op_store  input  1  current instruction is a store (sampled in phase 4)
mem_addr  input  16  data word address (ALU result)
store_data  input  16  store write data
data_bus  output  16  registered instruction word for the fetch stage
load_data  output  16  registered load result
phase_stall  output  1  high = sequencer must hold the current phase
ram_addr  output  ADDR_WIDTH  RAM address
ram_wdata  output  16  RAM write data
ram_we  output  1  RAM write enable, single-cycle pulse
ram_rdata  input  16  RAM read data
addr_fault  output  1  sticky: out-of-range address or load+store conflict

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; data_bus=16'hC000 (INSN_RESET_WORD); load_data=0; phase_stall=0; ram_we=0; ram_addr=0; ram_wdata=0; addr_fault=0. Reset aborts any in-flight access, and no ram_we pulse is issued afterwards.
- States: IDLE, FETCH_WAIT, LOAD_WAIT, DONE. A wait counter counts down from READ_LATENCY.
- IDLE, phase_counter==3'b001:
  - ram_addr<=program_counter[ADDR_WIDTH-1:0], phase_stall<=1, next state FETCH_WAIT.
- IDLE, phase_counter==3'b100, op_load only:
  - ram_addr<=mem_addr, phase_stall<=1, next state LOAD_WAIT.
- IDLE, phase 4, op_store only:
  - ram_we<=1 for exactly one cycle, with ram_addr/ram_wdata valid in the same cycle.
  - No stall. Next state DONE.
- IDLE, phase 4, op_load and op_store both high:
  - No RAM access. addr_fault<=1, load_data unchanged, next state DONE.
- IDLE, phase 4, neither op asserted: next state DONE; no access.
- FETCH_WAIT / LOAD_WAIT: decrement the counter each cycle. In the cycle it reaches zero:
  - Capture ram_rdata into data_bus (fetch) or load_data (load).
  - phase_stall<=0, next state DONE.
  - A registered word is visible on the same edge at which phase_stall falls.
- Stall timing: phase_stall is high for exactly READ_LATENCY+1 cycles per read, counted from the first cycle of the phase. While stalled, the fetch stage relatches data_bus every cycle; the value it holds in the final, non-stalled phase-1 cycle is the fetched word.
- DONE: stay until phase_counter differs from the serviced phase, then IDLE. There is no retrigger within the same phase.
- Out-of-range access: address bits [15:ADDR_WIDTH] nonzero.
  - No RAM access, no ram_we. Stall timing is unchanged.
  - addr_fault<=1.
  - Returned word is INSN_RESET_WORD for a fetch and 16'h0000 for a load. Stores are dropped.
- addr_fault clears only on reset.
- Other phases (2, 3, 5, 0): no access; outputs hold.

Decomposition:
- Package mem_bus_pkg holds:
  - Phase encodings PH_FETCH=3'b001, PH_MEM=3'b100.
  - INSN_RESET_WORD=16'hC000.
  - State enum.
  - Helper for the range check.
- One natural sub-module: mem_wait_counter, a loadable down-counter with a zero flag. The FSM uses it for READ_LATENCY.

Test Plan:
- Reset then release with RAM[5]=16'h1234, pc=5, phase 1, READ_LATENCY=1 -> phase_stall high 2 cycles; data_bus=16'h1234 when stall falls.
- Phase 4 store, mem_addr=16'h0010, store_data=16'hBEEF -> single ram_we pulse, no stall; a later load of 16'h0010 returns load_data=16'hBEEF after READ_LATENCY+1 stall cycles.
- READ_LATENCY=3, fetch -> phase_stall high exactly 4 cycles; phase held at 1 generates no second RAM access.
- Phase 4 with op_load=op_store=1 -> no ram_we; addr_fault=1; load_data unchanged.
- Fetch with pc=16'hF000 (out of range at ADDR_WIDTH=12) -> data_bus=16'hC000, addr_fault=1, no ram_we.
- Assert reset during LOAD_WAIT -> next cycle state IDLE, phase_stall=0, load_data=0, data_bus=16'hC000, no stale capture afterwards.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and helpers for the memory-side bus responder.
package mem_bus_pkg;

    // Sequencer phase encodings the responder reacts to
    localparam logic [2:0] PH_FETCH = 3'b001;
    localparam logic [2:0] PH_MEM   = 3'b100;

    // Word presented to the fetch stage after reset or on a faulting fetch
    localparam logic [15:0] INSN_RESET_WORD = 16'hC000;

    // Responder state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_FETCH_WAIT = 2'd1;
    localparam state_t ST_LOAD_WAIT  = 2'd2;
    localparam state_t ST_DONE       = 2'd3;

    // Wait counter width; covers read latencies up to 7
    localparam int WAIT_CNT_W = 3;

    // True when any address bit above the implemented RAM width is set
    function automatic logic addr_out_of_range(input logic [15:0] addr, input int width);
        return (addr >> width) != 16'h0000;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag, used to time RAM read latency.
module mem_wait_counter
    import mem_bus_pkg::*;
#(
    parameter int WIDTH = WAIT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: instruction fetch in phase 1, load/store in phase 4,
// against a synchronous single-port RAM with a fixed read latency.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            phase_counter,
    input  logic [15:0]           program_counter,
    input  logic                  op_load,
    input  logic                  op_store,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           store_data,
    output logic [15:0]           data_bus,
    output logic [15:0]           load_data,
    output logic                  phase_stall,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_wdata,
    output logic                  ram_we,
    input  logic [15:0]           ram_rdata,
    output logic                  addr_fault
);

    state_t                state;
    logic [2:0]            served_phase;  // phase that was serviced, for DONE exit
    logic                  read_oob;      // current read was out of range: return a fixed word
    logic                  pc_oob;
    logic                  ma_oob;
    logic                  is_idle;
    logic                  fetch_req;
    logic                  load_req;
    logic                  store_req;
    logic                  conflict_req;
    logic                  start_read;
    logic                  in_wait;
    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  wait_zero;

    // Request decode from the current phase and opcode flags
    always_comb begin
        pc_oob       = addr_out_of_range(program_counter, ADDR_WIDTH);
        ma_oob       = addr_out_of_range(mem_addr, ADDR_WIDTH);
        is_idle      = (state == ST_IDLE);
        fetch_req    = is_idle && (phase_counter == PH_FETCH);
        load_req     = is_idle && (phase_counter == PH_MEM) && op_load && !op_store;
        store_req    = is_idle && (phase_counter == PH_MEM) && op_store && !op_load;
        conflict_req = is_idle && (phase_counter == PH_MEM) && op_load && op_store;
        start_read   = fetch_req || load_req;
        in_wait      = (state == ST_FETCH_WAIT) || (state == ST_LOAD_WAIT);
    end

    // Out-of-range reads still run the counter so stall timing is identical
    mem_wait_counter #(
        .WIDTH(WAIT_CNT_W)
    ) u_wait (
        .clock     (clock),
        .reset     (reset),
        .load      (start_read),
        .load_value(WAIT_CNT_W'(READ_LATENCY)),
        .dec       (in_wait),
        .count     (wait_count),
        .zero      (wait_zero)
    );

    // Main sequencer: dispatch in IDLE, capture on counter expiry, wait out the phase in DONE
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ST_IDLE;
            served_phase <= 3'b000;
            read_oob     <= 1'b0;
            data_bus     <= INSN_RESET_WORD;
            load_data    <= 16'h0000;
            phase_stall  <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= 16'h0000;
            addr_fault   <= 1'b0;
        end else begin
            // Write enable is only ever a single-cycle pulse
            ram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        served_phase <= PH_FETCH;
                        phase_stall  <= 1'b1;
                        read_oob     <= pc_oob;
                        state        <= ST_FETCH_WAIT;
                        if (pc_oob) begin
                            addr_fault <= 1'b1;
                        end else begin
                            ram_addr <= program_counter[ADDR_WIDTH-1:0];
                        end
                    end else if (load_req) begin
                        served_phase <= PH_MEM;
                        phase_stall  <= 1'b1;
                        read_oob     <= ma_oob;
                        state        <= ST_LOAD_WAIT;
                        if (ma_oob) begin
                            addr_fault <= 1'b1;
                        end else begin
                            ram_addr <= mem_addr[ADDR_WIDTH-1:0];
                        end
                    end else if (store_req) begin
                        served_phase <= PH_MEM;
                        state        <= ST_DONE;
                        if (ma_oob) begin
                            addr_fault <= 1'b1;
                        end else begin
                            ram_we    <= 1'b1;
                            ram_addr  <= mem_addr[ADDR_WIDTH-1:0];
                            ram_wdata <= store_data;
                        end
                    end else if (conflict_req) begin
                        // Ambiguous op: touch nothing, just flag it
                        served_phase <= PH_MEM;
                        addr_fault   <= 1'b1;
                        state        <= ST_DONE;
                    end else if (phase_counter == PH_MEM) begin
                        served_phase <= PH_MEM;
                        state        <= ST_DONE;
                    end
                end
                ST_FETCH_WAIT: begin
                    if (wait_zero) begin
                        data_bus    <= read_oob ? INSN_RESET_WORD : ram_rdata;
                        phase_stall <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_LOAD_WAIT: begin
                    if (wait_zero) begin
                        load_data   <= read_oob ? 16'h0000 : ram_rdata;
                        phase_stall <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Holding the same phase must not start a second access
                    if (phase_counter != served_phase) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: two responders (read latency 1 and 3), each with its own
// RAM, driven phase by phase against a phase-level model of the bus behaviour.
module tb_mem_bus_responder;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset       [2];
    logic [2:0]    phase       [2];
    logic [15:0]   pc          [2];
    logic          op_load     [2];
    logic          op_store    [2];
    logic [15:0]   mem_addr    [2];
    logic [15:0]   store_data  [2];
    logic [15:0]   data_bus    [2];
    logic [15:0]   load_data   [2];
    logic          phase_stall [2];
    logic [AW-1:0] ram_addr    [2];
    logic [15:0]   ram_wdata   [2];
    logic          ram_we      [2];
    logic [15:0]   ram_rdata   [2];
    logic          addr_fault  [2];

    // Expected outputs for the current cycle, per instance
    logic          chk_en    [2];
    logic          exp_stall [2];
    logic          exp_we    [2];
    logic          exp_achk  [2];
    logic [AW-1:0] exp_addr  [2];
    logic [15:0]   exp_wdata [2];
    logic [15:0]   exp_db    [2];
    logic [15:0]   exp_ld    [2];
    logic          exp_fault [2];
    logic [15:0]   shadow    [2][DEPTH];

    int tests = 0;
    int fails = 0;
    int stall_cnt [2];
    int we_cnt    [2];

    function automatic logic [15:0] init_word(input int i);
        if (i == 5) return 16'h1234;
        return 16'(i * 7) ^ 16'h3C5A;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    mem_bus_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset[0]), .phase_counter(phase[0]), .program_counter(pc[0]),
        .op_load(op_load[0]), .op_store(op_store[0]), .mem_addr(mem_addr[0]), .store_data(store_data[0]),
        .data_bus(data_bus[0]), .load_data(load_data[0]), .phase_stall(phase_stall[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_we(ram_we[0]), .ram_rdata(ram_rdata[0]),
        .addr_fault(addr_fault[0])
    );

    mem_bus_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut_l3 (
        .clock(clock), .reset(reset[1]), .phase_counter(phase[1]), .program_counter(pc[1]),
        .op_load(op_load[1]), .op_store(op_store[1]), .mem_addr(mem_addr[1]), .store_data(store_data[1]),
        .data_bus(data_bus[1]), .load_data(load_data[1]), .phase_stall(phase_stall[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_we(ram_we[1]), .ram_rdata(ram_rdata[1]),
        .addr_fault(addr_fault[1])
    );

    // Synchronous RAM per instance with a read pipeline of the instance's latency
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] mem [DEPTH];
        logic [15:0] rpipe [4];
        logic ready = 1'b0;
        always @(posedge clock) begin
            if (!ready) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
                ready <= 1'b1;
            end else if (ram_we[g]) begin
                mem[ram_addr[g]] <= ram_wdata[g];
            end
            rpipe[0] <= mem[ram_addr[g]];
            for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
        end
        assign ram_rdata[g] = rpipe[LAT-1];
    end

    task automatic check(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_en[k]) begin
                if (phase_stall[k] === 1'b1) stall_cnt[k]++;
                if (ram_we[k] === 1'b1) we_cnt[k]++;
                check("phase_stall", k, 16'(phase_stall[k]), 16'(exp_stall[k]));
                check("ram_we", k, 16'(ram_we[k]), 16'(exp_we[k]));
                check("data_bus", k, data_bus[k], exp_db[k]);
                check("load_data", k, load_data[k], exp_ld[k]);
                check("addr_fault", k, 16'(addr_fault[k]), 16'(exp_fault[k]));
                if (exp_achk[k] || exp_we[k]) check("ram_addr", k, 16'(ram_addr[k]), 16'(exp_addr[k]));
                if (exp_we[k]) check("ram_wdata", k, ram_wdata[k], exp_wdata[k]);
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // One sequencer phase: entry cycle, stall cycles if a read, one free cycle, then extra holds
    task automatic run_phase(input int k, input logic [2:0] ph, input logic [15:0] a_pc, input logic [15:0] a_ma,
                             input logic [15:0] a_wd, input logic ld, input logic st, input int extra);
        int   lat;
        int   n;
        logic rd;
        logic oob;
        logic flt;
        lat = lat_of(k);
        phase[k] = ph; pc[k] = a_pc; mem_addr[k] = a_ma; store_data[k] = a_wd;
        op_load[k] = ld; op_store[k] = st;
        rd  = (ph == 3'd1) || (ph == 3'd4 && ld && !st);
        oob = (ph == 3'd1) ? (a_pc[15:12] != 4'd0) : (a_ma[15:12] != 4'd0);
        flt = (ph == 3'd1 && oob) || (ph == 3'd4 && ((ld && st) || ((ld ^ st) && oob)));
        n   = (rd ? lat + 3 : 2) + extra;
        for (int c = 0; c < n; c++) begin
            exp_stall[k] = rd && c >= 1 && c <= lat + 1;
            exp_we[k]    = (ph == 3'd4) && st && !ld && !oob && c == 1;
            exp_achk[k]  = rd && !oob && c >= 1 && c <= lat + 1;
            exp_addr[k]  = (ph == 3'd1) ? a_pc[11:0] : a_ma[11:0];
            exp_wdata[k] = a_wd;
            if (flt && c == 1) exp_fault[k] = 1'b1;
            if (rd && c == lat + 2) begin
                if (ph == 3'd1) exp_db[k] = oob ? 16'hC000 : shadow[k][a_pc[11:0]];
                else            exp_ld[k] = oob ? 16'h0000 : shadow[k][a_ma[11:0]];
            end
            if (exp_we[k]) shadow[k][a_ma[11:0]] = a_wd;
            cycle();
        end
    endtask

    // Reset asserted for one cycle from whatever state; outputs unchanged until the edge
    task automatic do_reset(input int k);
        reset[k] = 1'b0; phase[k] = 3'd0; op_load[k] = 1'b0; op_store[k] = 1'b0;
        exp_we[k] = 1'b0; exp_achk[k] = 1'b0;
        cycle();
        exp_stall[k] = 1'b0; exp_db[k] = 16'hC000; exp_ld[k] = 16'h0000; exp_fault[k] = 1'b0;
        reset[k] = 1'b1;
        cycle();
        cycle();
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return {4'($urandom_range(1, 15)), 12'($urandom_range(0, 15))};
        return 16'($urandom_range(0, 15));
    endfunction

    task automatic random_rounds(input int k, input int rounds);
        logic [15:0] a_pc;
        logic [15:0] a_ma;
        logic [15:0] a_wd;
        logic [1:0]  ops;
        for (int r = 0; r < rounds; r++) begin
            for (int p = 1; p <= 5; p++) begin
                a_pc = rand_addr();
                a_ma = rand_addr();
                a_wd = 16'($urandom);
                ops  = 2'($urandom_range(0, 3));
                run_phase(k, 3'(p), a_pc, a_ma, a_wd, ops[0], ops[1], int'($urandom_range(0, 2)));
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t simulation did not finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int s0;
        int w0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) shadow[k][i] = init_word(i);
            reset[k] = 1'b0; phase[k] = 3'd0; pc[k] = 16'h0; op_load[k] = 1'b0; op_store[k] = 1'b0;
            mem_addr[k] = 16'h0; store_data[k] = 16'h0; chk_en[k] = 1'b0;
            stall_cnt[k] = 0; we_cnt[k] = 0;
            exp_stall[k] = 1'b0; exp_we[k] = 1'b0; exp_achk[k] = 1'b0; exp_addr[k] = '0; exp_wdata[k] = 16'h0;
            exp_db[k] = 16'hC000; exp_ld[k] = 16'h0000; exp_fault[k] = 1'b0;
        end
        cycle();
        chk_en[0] = 1'b1; chk_en[1] = 1'b1;
        cycle();
        cycle();
        check("reset_data_bus", 0, data_bus[0], 16'hC000);
        check("reset_load_data", 0, load_data[0], 16'h0000);
        check("reset_stall", 0, 16'(phase_stall[0]), 16'h0);
        check("reset_fault", 0, 16'(addr_fault[0]), 16'h0);
        check("reset_ram_addr", 0, 16'(ram_addr[0]), 16'h0);
        reset[0] = 1'b1; reset[1] = 1'b1;

        // Latency 1: fetch of RAM[5]
        s0 = stall_cnt[0];
        run_phase(0, 3'd1, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        check("fetch_word", 0, data_bus[0], 16'h1234);
        check("fetch_stall_len", 0, 16'(stall_cnt[0] - s0), 16'd2);
        run_phase(0, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        // Store then load back
        s0 = stall_cnt[0]; w0 = we_cnt[0];
        run_phase(0, 3'd4, 16'h0, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 0);
        check("store_we_pulses", 0, 16'(we_cnt[0] - w0), 16'd1);
        check("store_stall_len", 0, 16'(stall_cnt[0] - s0), 16'd0);
        run_phase(0, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd1, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        s0 = stall_cnt[0];
        run_phase(0, 3'd4, 16'h0, 16'h0010, 16'h0, 1'b1, 1'b0, 0);
        check("load_word", 0, load_data[0], 16'hBEEF);
        check("load_stall_len", 0, 16'(stall_cnt[0] - s0), 16'd2);
        run_phase(0, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        // Out-of-range fetch
        w0 = we_cnt[0];
        run_phase(0, 3'd1, 16'hF000, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        check("oob_fetch_word", 0, data_bus[0], 16'hC000);
        check("oob_fetch_fault", 0, 16'(addr_fault[0]), 16'h1);
        check("oob_fetch_we", 0, 16'(we_cnt[0] - w0), 16'd0);
        // Clear fault, then load+store conflict
        do_reset(0);
        check("fault_cleared", 0, 16'(addr_fault[0]), 16'h0);
        run_phase(0, 3'd1, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd4, 16'h0, 16'h0010, 16'h0, 1'b1, 1'b0, 0);
        run_phase(0, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd1, 16'h0002, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(0, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        check("pre_conflict_fault", 0, 16'(addr_fault[0]), 16'h0);
        w0 = we_cnt[0];
        run_phase(0, 3'd4, 16'h0, 16'h0011, 16'h5555, 1'b1, 1'b1, 1);
        check("conflict_we", 0, 16'(we_cnt[0] - w0), 16'd0);
        check("conflict_fault", 0, 16'(addr_fault[0]), 16'h1);
        check("conflict_load_data", 0, load_data[0], 16'hBEEF);
        run_phase(0, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        random_rounds(0, 40);

        // Latency 3: fetch with the phase held long after the stall
        do_reset(1);
        s0 = stall_cnt[1]; w0 = we_cnt[1];
        run_phase(1, 3'd1, 16'h0005, 16'h0, 16'h0, 1'b0, 1'b0, 3);
        check("l3_fetch_stall_len", 1, 16'(stall_cnt[1] - s0), 16'd4);
        check("l3_fetch_word", 1, data_bus[1], 16'h1234);
        check("l3_fetch_we", 1, 16'(we_cnt[1] - w0), 16'd0);
        run_phase(1, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(1, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(1, 3'd4, 16'h0, 16'h0020, 16'hA5C3, 1'b0, 1'b1, 0);
        run_phase(1, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(1, 3'd1, 16'h0003, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(1, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        run_phase(1, 3'd3, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        s0 = stall_cnt[1];
        run_phase(1, 3'd4, 16'h0, 16'h0020, 16'h0, 1'b1, 1'b0, 0);
        check("l3_load_word", 1, load_data[1], 16'hA5C3);
        check("l3_load_stall_len", 1, 16'(stall_cnt[1] - s0), 16'd4);
        run_phase(1, 3'd5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
        random_rounds(1, 30);

        // Reset in the middle of a latency-3 load; no capture may follow
        phase[1] = 3'd4; mem_addr[1] = 16'h0007; op_load[1] = 1'b1; op_store[1] = 1'b0;
        exp_stall[1] = 1'b0; exp_we[1] = 1'b0; exp_achk[1] = 1'b0;
        cycle();
        exp_stall[1] = 1'b1; exp_achk[1] = 1'b1; exp_addr[1] = 12'h007;
        cycle();
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle();
        check("midreset_stall", 1, 16'(phase_stall[1]), 16'h0);
        check("midreset_load_data", 1, load_data[1], 16'h0000);
        check("midreset_data_bus", 1, data_bus[1], 16'hC000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
